nios_blink_led_fader: RTL and testbench
=======================================

# nios_blink_led_fader

Per-LED fade/PWM driver sitting directly downstream of the 4-bit blink PIO output port: it consumes the PIO's `out_port` levels and drives the four board LED pins. Each channel has an 8-bit brightness level that ramps linearly toward full-on or full-off to follow its PIO bit. A PWM comparator turns the level into an LED drive. A small Avalon-MM slave (zero-wait-state, same bus shape as the PIO) gives Nios software control and status.

## Interface
Parameters:
- `NCH`, 4, number of LED channels (must match PIO width).
- `PRESCALE_W`, 16, width of fade prescaler.
- `PRESCALE_RST`, 16'd382, reset value of prescale register (about 0.5 s full ramp at 50 MHz).

Ports:
- `clk`  in  1  system clock, one clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pio_in`  in  NCH  target levels, from PIO `out_port` (same clock domain, no synchroniser).
- `address`  in  2  Avalon word address.
- `chipselect`  in  1  Avalon select.
- `write_n`  in  1  Avalon write strobe, active-low.
- `writedata`  in  32  Avalon write data.
- `readdata`  out  32  Avalon read data, combinational from `address`.
- `led_out`  out  NCH  LED drive, registered.

## Operation
- Registers:
  - addr0 CTRL (rw): bit0 `enable`, bit1 `bypass`. Bits [31:2] read 0.
  - addr1 PRESCALE (rw): bits [PRESCALE_W-1:0].
  - addr2 LEVEL (ro): {level3, level2, level1, level0}, 8 bits each.
  - addr3 STATUS (ro): [3:0] `pio_in`, [7:4] ramping flags (level differs from target), remaining bits 0.
- Write occurs when `chipselect && !write_n`. Writes to addr2 and addr3 are ignored.
- PWM counter: 8-bit free-running, wraps 255→0.
- Divider counter: decrements once per PWM wrap. When it is 0 at a wrap, the cycle is a `tick` and the divider reloads from PRESCALE.
- On `tick`, per channel: target 1 and level<255 → level+1; target 0 and level>0 → level−1; otherwise hold (saturate, no wrap).
- Target change mid-ramp: ramp reverses from the current level on the next tick. No reset of the level.
- Bypass=1: every cycle, level[i] ← {8{pio_in[i]}} and `led_out` = `pio_in`. Leaving bypass resumes fading from the snapped level, so there is no glitch.
- Compare: `drive[i]` = (level==255) | (level > pwm_cnt). Level 0 gives 0% duty, level 255 gives 100%, level N (1..254) gives N/256.
- `led_out` ← enable ? drive : 0. Fade logic runs regardless of `enable`.

## Timing
- Reset values: `led_out`=0, CTRL=0x1 (enabled, not bypassed), PRESCALE=PRESCALE_RST, all levels 0, PWM counter 0, divider 0, `readdata` reflects the reset registers.
- Register write takes effect on the clock edge of the write. A CTRL change shows on `led_out` one cycle later.
- PRESCALE write: the new value is used at the next reload. The divider counter is not disturbed mid-count.
- `pio_in` → `led_out` latency in bypass: 1 clk.
- Tick spacing: 256·(PRESCALE+1) clk. Full 0→255 ramp: 255 ticks.
- Simultaneous tick and bypass: bypass wins. Simultaneous tick and target change: the tick uses the new target (`pio_in` sampled same cycle).
- Reset asserted mid-ramp: all state returns to reset values asynchronously. The ramp restarts from 0 after release.
- Reads have zero wait states. Read data is not registered.

## Structure
- Package `nios_blink_led_fader_pkg`:
  - register address constants CTRL/PRESCALE/LEVEL/STATUS
  - CTRL bit indices
  - `PRESCALE_RST`
  - level width (8) constant
- Sub-module `nios_blink_led_fader_chan`:
  - one channel's level register, saturating up/down, bypass snap, compare against shared `pwm_cnt`
  - generated NCH times
- Top holds the Avalon decode, CTRL/PRESCALE registers, PWM counter, divider/tick and output register.

## Test plan
- Reset → `led_out`=0; reads return addr0=0x1, addr1=382, addr2=0, addr3=0.
- PRESCALE=0, `pio_in`=4'b0001 → level0 increments every 256 clk and reaches 255 after 255·256 clk; `led_out[0]` duty tracks the level; at 255, `led_out[0]` stays constantly 1; STATUS[4] drops to 0.
- Ramp reversal: at level0=100, set `pio_in`=0 → next tick gives 99; it decays to 0 and holds; level 0 gives `led_out[0]` constantly 0.
- CTRL=0x3 (bypass), toggle `pio_in` 0xA→0x5 → `led_out` follows 1 clk later; LEVEL reads 0x00FF00FF. Clearing bypass gives no output glitch.
- CTRL=0x0 with `pio_in`=0xF → `led_out`=0 while LEVEL keeps ramping. Re-enabling shows PWM at the current levels.
- Assert `reset_n` mid-ramp (level≈128) → outputs and levels read 0 immediately. A write to addr2 is ignored.

Source files
------------

// File: rtl/nios_blink_led_fader_pkg.sv
// Shared constants and types for the blink LED fader: register map,
// CTRL bit positions, reset prescale and brightness level width.
package nios_blink_led_fader_pkg;

    // Avalon word addresses
    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_PRESCALE = 2'd1;
    localparam logic [1:0] ADDR_LEVEL    = 2'd2;
    localparam logic [1:0] ADDR_STATUS   = 2'd3;

    // CTRL bit indices
    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_BYPASS_BIT = 1;

    // About 0.5 s for a full 0->255 ramp at 50 MHz
    localparam logic [15:0] PRESCALE_RST = 16'd382;

    // Brightness level / PWM counter width
    localparam int LEVEL_W = 8;

    typedef struct packed {
        logic bypass;
        logic enable;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{bypass: 1'b0, enable: 1'b1};

endpackage

// File: rtl/nios_blink_led_fader_chan.sv
// One LED channel: saturating brightness ramp toward the PIO target,
// bypass snap, and PWM compare against the shared counter.
module nios_blink_led_fader_chan
    import nios_blink_led_fader_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               target,
    input  logic               tick,
    input  logic               bypass,
    input  logic [LEVEL_W-1:0] pwm_cnt,
    output logic [LEVEL_W-1:0] level,
    output logic               ramping,
    output logic               drive
);

    localparam logic [LEVEL_W-1:0] LVL_MAX = '1;
    localparam logic [LEVEL_W-1:0] LVL_MIN = '0;

    // Level: bypass snaps to the target rail, otherwise step one per tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
        end else if (bypass) begin
            level <= {LEVEL_W{target}};
        end else if (tick) begin
            if (target && level != LVL_MAX)
                level <= level + 1'b1;
            else if (!target && level != LVL_MIN)
                level <= level - 1'b1;
        end
    end

    assign ramping = (level != {LEVEL_W{target}});

    // Full scale is forced on so 255 gives 100% rather than 255/256
    assign drive = (level == LVL_MAX) || (level > pwm_cnt);

endmodule

// File: rtl/nios_blink_led_fader.sv
// PWM fade driver between the blink PIO and the board LEDs, with a
// zero-wait-state Avalon-MM slave for control and status.
module nios_blink_led_fader #(
    parameter int                    NCH          = 4,
    parameter int                    PRESCALE_W   = 16,
    parameter logic [PRESCALE_W-1:0] PRESCALE_RST = nios_blink_led_fader_pkg::PRESCALE_RST
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [NCH-1:0] pio_in,
    input  logic [1:0]     address,
    input  logic           chipselect,
    input  logic           write_n,
    input  logic [31:0]    writedata,
    output logic [31:0]    readdata,
    output logic [NCH-1:0] led_out
);

    import nios_blink_led_fader_pkg::*;

    // Register map only has room for four 8-bit levels / status nibbles
    localparam int NV = (NCH < 4) ? NCH : 4;

    ctrl_t                         ctrl;
    logic [PRESCALE_W-1:0]         prescale;
    logic [PRESCALE_W-1:0]         div_cnt;
    logic [LEVEL_W-1:0]            pwm_cnt;
    logic                          pwm_wrap;
    logic                          tick;
    logic                          wr_en;
    logic [NCH-1:0][LEVEL_W-1:0]   level;
    logic [NCH-1:0]                ramping;
    logic [NCH-1:0]                drive;

    assign wr_en    = chipselect && !write_n;
    assign pwm_wrap = (pwm_cnt == {LEVEL_W{1'b1}});
    assign tick     = pwm_wrap && (div_cnt == '0);

    // CTRL / PRESCALE registers; LEVEL and STATUS writes fall through
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl     <= CTRL_RST;
            prescale <= PRESCALE_RST;
        end else if (wr_en) begin
            case (address)
                ADDR_CTRL: begin
                    ctrl.enable <= writedata[CTRL_ENABLE_BIT];
                    ctrl.bypass <= writedata[CTRL_BYPASS_BIT];
                end
                ADDR_PRESCALE: prescale <= writedata[PRESCALE_W-1:0];
                default: ;
            endcase
        end
    end

    // Free-running PWM counter; divider only moves on a wrap, so a
    // PRESCALE write lands at the next reload without upsetting the count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
            div_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_wrap)
                div_cnt <= (div_cnt == '0) ? prescale : div_cnt - 1'b1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        nios_blink_led_fader_chan u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .target  (pio_in[g]),
            .tick    (tick),
            .bypass  (ctrl.bypass),
            .pwm_cnt (pwm_cnt),
            .level   (level[g]),
            .ramping (ramping[g]),
            .drive   (drive[g])
        );
    end

    // LED drive: bypass passes the PIO straight through, enable gates all
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            led_out <= '0;
        else if (!ctrl.enable)
            led_out <= '0;
        else if (ctrl.bypass)
            led_out <= pio_in;
        else
            led_out <= drive;
    end

    // Unregistered read mux
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[CTRL_ENABLE_BIT] = ctrl.enable;
                readdata[CTRL_BYPASS_BIT] = ctrl.bypass;
            end
            ADDR_PRESCALE: readdata[PRESCALE_W-1:0] = prescale;
            ADDR_LEVEL: begin
                for (int i = 0; i < NV; i++)
                    readdata[i*LEVEL_W +: LEVEL_W] = level[i];
            end
            default: begin
                for (int i = 0; i < NV; i++) begin
                    readdata[i]     = pio_in[i];
                    readdata[4 + i] = ramping[i];
                end
            end
        endcase
    end

endmodule

// File: tb/tb_nios_blink_led_fader.sv
`timescale 1ns/1ps
module tb_nios_blink_led_fader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  pio_in = '0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [3:0]  led_out;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    nios_blink_led_fader #(.NCH(4), .PRESCALE_W(16), .PRESCALE_RST(16'd382)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pio_in     (pio_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .led_out    (led_out)
    );

    always #50 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance n clocks; we always sit just after a falling edge
    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
        cyc += n;
    endtask

    task automatic run_to(input int t);
        if (t > cyc) clk_n(t - cyc);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        clk_n(1);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(name, readdata, exp);
    endtask

    // Count high samples of led_out[0] and [1] across one 256-clock PWM period
    task automatic duty(input string name, input int exp0, input int exp1);
        int c0, c1;
        c0 = 0; c1 = 0;
        repeat (256) begin
            clk_n(1);
            c0 += int'(led_out[0]);
            c1 += int'(led_out[1]);
        end
        chk({name, "_ch0"}, c0, exp0);
        chk({name, "_ch1"}, c1, exp1);
    endtask

    initial begin
        int cnt, t0;

        tbl[0]  = '{1'b0, 2'd0, 32'h0,        32'h1,    "rst_ctrl"};
        tbl[1]  = '{1'b0, 2'd1, 32'h0,        32'd382,  "rst_prescale"};
        tbl[2]  = '{1'b0, 2'd2, 32'h0,        32'h0,    "rst_level"};
        tbl[3]  = '{1'b0, 2'd3, 32'h0,        32'h0,    "rst_status"};
        tbl[4]  = '{1'b1, 2'd1, 32'h0001ABCD, 32'hABCD, "prescale_trunc"};
        tbl[5]  = '{1'b1, 2'd0, 32'hFFFFFFFC, 32'h0,    "ctrl_clear"};
        tbl[6]  = '{1'b1, 2'd0, 32'hFFFFFFFF, 32'h3,    "ctrl_all"};
        tbl[7]  = '{1'b1, 2'd0, 32'h00000001, 32'h1,    "ctrl_enable"};
        tbl[8]  = '{1'b1, 2'd2, 32'hDEADBEEF, 32'h0,    "level_ro"};
        tbl[9]  = '{1'b1, 2'd3, 32'hFFFFFFFF, 32'h0,    "status_ro"};
        tbl[10] = '{1'b1, 2'd1, 32'h00000000, 32'h0,    "prescale_zero"};

        // Held in reset
        repeat (3) @(negedge clk);
        chk("rst_led", {28'd0, led_out}, 32'h0);
        reset_n = 1'b1;
        cyc = 0;

        // Register map, all done well before the first PWM wrap
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].wr) wr(tbl[i].addr, tbl[i].wdata);
            rd_chk(tbl[i].name, tbl[i].addr, tbl[i].exp);
        end

        // Ramp ch0 and ch1 up with PRESCALE=0: one level step every 256 clk
        pio_in = 4'b0011;
        rd_chk("status_start", 2'd3, 32'h33);
        run_to(256);
        rd_chk("level_t1", 2'd2, 32'h0000_0101);
        run_to(256 * 100);
        rd_chk("level_t100", 2'd2, 32'h0000_6464);

        // Reverse ch1 mid-ramp
        pio_in = 4'b0001;
        rd_chk("status_rev", 2'd3, 32'h31);
        run_to(256 * 101);
        rd_chk("level_t101", 2'd2, 32'h0000_6365);
        duty("duty_t101", 101, 99);

        // Disabled: outputs dark, levels keep moving
        wr(2'd0, 32'h0);
        cnt = 0;
        repeat (600) begin
            clk_n(1);
            if (led_out != 4'h0) cnt++;
        end
        chk("disabled_led", cnt, 0);
        rd_chk("level_disabled", 2'd2, 32'h0000_6068);
        wr(2'd0, 32'h1);
        run_to(256 * 105);
        duty("duty_t105", 105, 95);

        // ch1 decayed to 0 and holds
        run_to(256 * 200);
        rd_chk("level_t200", 2'd2, 32'h0000_00C8);
        rd_chk("status_t200", 2'd3, 32'h11);
        duty("duty_t200", 200, 0);

        // ch0 at full scale, saturates
        run_to(256 * 255);
        rd_chk("level_t255", 2'd2, 32'h0000_00FF);
        rd_chk("status_t255", 2'd3, 32'h01);
        duty("duty_t255", 256, 0);
        rd_chk("level_sat", 2'd2, 32'h0000_00FF);

        // Bypass
        pio_in = 4'hA;
        wr(2'd0, 32'h3);
        clk_n(1);
        chk("byp_led_a", {28'd0, led_out}, 32'hA);
        rd_chk("byp_level_a", 2'd2, 32'hFF00_FF00);
        pio_in = 4'h5;
        chk("byp_led_hold", {28'd0, led_out}, 32'hA);
        clk_n(1);
        chk("byp_led_5", {28'd0, led_out}, 32'h5);
        rd_chk("byp_level_5", 2'd2, 32'h00FF_00FF);

        // Leave bypass without a glitch
        wr(2'd0, 32'h1);
        chk("unbyp_led", {28'd0, led_out}, 32'h5);
        cnt = 0;
        repeat (300) begin
            clk_n(1);
            if (led_out != 4'h5) cnt++;
        end
        chk("unbyp_glitch", cnt, 0);

        // Ramp ch1/ch3 for 10 ticks, then reset mid-ramp
        pio_in = 4'hF;
        t0 = (cyc / 256 + 1) * 256;
        run_to(t0 + 256 * 9);
        rd_chk("level_preRst", 2'd2, 32'h0AFF_0AFF);
        reset_n = 1'b0;
        #1;
        chk("midrst_led", {28'd0, led_out}, 32'h0);
        rd_chk("midrst_level", 2'd2, 32'h0);
        rd_chk("midrst_ctrl", 2'd0, 32'h1);
        rd_chk("midrst_prescale", 2'd1, 32'd382);
        rd_chk("midrst_status", 2'd3, 32'hFF);

        // Restart, PRESCALE=1: first tick uses reset divider, then every 512
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        wr(2'd1, 32'h1);
        wr(2'd2, 32'h12345678);
        rd_chk("post_level_ro", 2'd2, 32'h0);
        run_to(256);
        rd_chk("post_t256", 2'd2, 32'h0101_0101);
        run_to(512);
        rd_chk("post_t512", 2'd2, 32'h0101_0101);
        run_to(768);
        rd_chk("post_t768", 2'd2, 32'h0202_0202);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
